// File: rtl/seq_det_pkg.sv
// Shared types for the sequence detector and its hit collector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_det_pkg;

    // Detector MODE encodings
    typedef enum logic [1:0] {
        MODE_ASC  = 2'd0,
        MODE_DESC = 2'd1,
        MODE_EQ   = 2'd2,
        MODE_OFF  = 2'd3
    } mode_t;

    // Occupancy state of the hit FIFO
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } occ_state_t;

    // One buffered hit: the mode that produced it and the completing value
    typedef struct packed {
        logic [1:0] mode;
        logic [3:0] data;
    } hit_entry_t;

    localparam int HIT_W    = $bits(hit_entry_t);
    localparam int TSTAMP_W = 16;

endpackage

// File: rtl/seq_hit_fifo.sv
// Generic synchronous first-word-fall-through FIFO with occupancy FSM and level.
// Latency: a push into an empty FIFO is visible at the head one cycle later.
// Backpressure: push while full is refused unless a pop happens in the same cycle.
module seq_hit_fifo
    import seq_det_pkg::*;
#(
    parameter  int W     = 6,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             SYSCLK,
    input  logic             RST,
    input  logic             push_vld,
    input  logic [W-1:0]     push_dat,
    input  logic             pop_rdy,
    output logic [W-1:0]     rd_dat,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    occ_state_t       state_q;
    occ_state_t       state_d;
    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             pop_ok;
    logic             push_ok;

    // A pop needs a stored entry; a push into a full FIFO only fits if the head leaves
    assign pop_ok  = pop_rdy && (state_q != EMPTY);
    assign push_ok = push_vld && ((state_q != FULL) || pop_ok);

    // Occupancy state register
    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy next state; simultaneous push and pop never change it
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: begin
                if (push_ok) state_d = PARTIAL;
            end
            PARTIAL: begin
                if (push_ok && !pop_ok && (level_q == LVL_W'(DEPTH - 1)))
                    state_d = FULL;
                else if (pop_ok && !push_ok && (level_q == LVL_W'(1)))
                    state_d = EMPTY;
            end
            FULL: begin
                if (pop_ok && !push_ok) state_d = PARTIAL;
            end
            default: state_d = EMPTY;
        endcase
    end

    // Status and head outputs; the head reads zero when nothing is stored
    always_comb begin
        full   = (state_q == FULL);
        empty  = (state_q == EMPTY);
        level  = level_q;
        rd_dat = empty ? '0 : mem[rd_ptr_q];
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge SYSCLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      level_q <= level_q + 1'b1;
            else if (pop_ok && !push_ok) level_q <= level_q - 1'b1;
        end
    end

    // Storage array; contents are meaningless until written, so no reset
    always_ff @(posedge SYSCLK) begin
        if (push_ok) mem[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/seq_hit_collector.sv
// Buffers detector hits in a FIFO, keeps saturating per-mode counters and a sticky drop flag.
// Latency: a hit into an empty FIFO appears on HIT_VALID/HIT_DATA one cycle later.
// Backpressure: HIT_READY low holds the head; hits arriving while full are dropped and flagged.
// Optional: SEQ_HIT_COLLECTOR_TSTAMP_EN adds a 16-bit cycle stamp per entry on HIT_TSTAMP.
module seq_hit_collector
    import seq_det_pkg::*;
#(
    parameter  int DEPTH = 8,
    parameter  int CNT_W = 8,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             SYSCLK,
    input  logic             RST,
    input  logic             DET_VALID,
    input  logic [3:0]       DET_DATA,
    input  logic [1:0]       DET_MODE,
    input  logic             CLR,
    output logic             HIT_VALID,
    input  logic             HIT_READY,
    output logic [5:0]       HIT_DATA,
    output logic [CNT_W-1:0] HIT_CNT0,
    output logic [CNT_W-1:0] HIT_CNT1,
    output logic [CNT_W-1:0] HIT_CNT2,
    output logic [LVL_W-1:0] LEVEL,
    output logic             OVERFLOW
`ifdef SEQ_HIT_COLLECTOR_TSTAMP_EN
    ,
    output logic [TSTAMP_W-1:0] HIT_TSTAMP
`endif
);

`ifdef SEQ_HIT_COLLECTOR_TSTAMP_EN
    localparam int FIFO_W = HIT_W + TSTAMP_W;
`else
    localparam int FIFO_W = HIT_W;
`endif

    hit_entry_t        push_entry;
    hit_entry_t        head_entry;
    logic [FIFO_W-1:0] push_dat;
    logic [FIFO_W-1:0] rd_dat;
    logic              fifo_full;
    logic              fifo_empty;
    logic              hit_push;
    logic              hit_pop;
    logic              hit_drop;
    logic [CNT_W-1:0]  cnt_q [3];
    logic              overflow_q;

    // MODE_OFF hits are ignored entirely
    assign hit_push   = DET_VALID && (mode_t'(DET_MODE) != MODE_OFF);
    assign hit_pop    = HIT_READY && !fifo_empty;
    assign hit_drop   = hit_push && fifo_full && !hit_pop;
    assign push_entry = '{mode: DET_MODE, data: DET_DATA};

`ifdef SEQ_HIT_COLLECTOR_TSTAMP_EN
    logic [TSTAMP_W-1:0] tstamp_q;

    // Free-running cycle stamp captured alongside each entry
    always_ff @(posedge SYSCLK) begin
        if (RST) tstamp_q <= '0;
        else     tstamp_q <= tstamp_q + 1'b1;
    end

    assign push_dat                 = {tstamp_q, push_entry};
    assign {HIT_TSTAMP, head_entry} = rd_dat;
`else
    assign push_dat   = push_entry;
    assign head_entry = hit_entry_t'(rd_dat);
`endif

    seq_hit_fifo #(
        .W     (FIFO_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .SYSCLK   (SYSCLK),
        .RST      (RST),
        .push_vld (hit_push),
        .push_dat (push_dat),
        .pop_rdy  (HIT_READY),
        .rd_dat   (rd_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (LEVEL)
    );

    assign HIT_VALID = !fifo_empty;
    assign HIT_DATA  = head_entry;

    // Per-mode saturating counters; clear beats a same-cycle hit, dropped hits still count
    always_ff @(posedge SYSCLK) begin
        for (int m = 0; m < 3; m++) begin
            if (RST || CLR) begin
                cnt_q[m] <= '0;
            end else if (hit_push && (DET_MODE == 2'(m)) && (cnt_q[m] != '1)) begin
                cnt_q[m] <= cnt_q[m] + 1'b1;
            end
        end
    end

    // Sticky drop flag; clear beats a same-cycle drop
    always_ff @(posedge SYSCLK) begin
        if (RST || CLR)    overflow_q <= 1'b0;
        else if (hit_drop) overflow_q <= 1'b1;
    end

    assign HIT_CNT0 = cnt_q[0];
    assign HIT_CNT1 = cnt_q[1];
    assign HIT_CNT2 = cnt_q[2];
    assign OVERFLOW = overflow_q;

endmodule

// File: tb/tb_seq_hit_collector.sv
// Bench for seq_hit_collector: vector table, directed corner sequences, random vs queue model.
// Latency: n/a.
// Backpressure: HIT_READY driven by the bench.
module tb_seq_hit_collector;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             SYSCLK = 1'b0;
    logic             RST;
    logic             DET_VALID;
    logic [3:0]       DET_DATA;
    logic [1:0]       DET_MODE;
    logic             CLR;
    logic             HIT_VALID;
    logic             HIT_READY;
    logic [5:0]       HIT_DATA;
    logic [CNT_W-1:0] HIT_CNT0;
    logic [CNT_W-1:0] HIT_CNT1;
    logic [CNT_W-1:0] HIT_CNT2;
    logic [LVL_W-1:0] LEVEL;
    logic             OVERFLOW;
`ifdef SEQ_HIT_COLLECTOR_TSTAMP_EN
    logic [15:0]      hit_tstamp;
`endif

    seq_hit_collector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .SYSCLK    (SYSCLK),
        .RST       (RST),
        .DET_VALID (DET_VALID),
        .DET_DATA  (DET_DATA),
        .DET_MODE  (DET_MODE),
        .CLR       (CLR),
        .HIT_VALID (HIT_VALID),
        .HIT_READY (HIT_READY),
        .HIT_DATA  (HIT_DATA),
        .HIT_CNT0  (HIT_CNT0),
        .HIT_CNT1  (HIT_CNT1),
        .HIT_CNT2  (HIT_CNT2),
        .LEVEL     (LEVEL),
        .OVERFLOW  (OVERFLOW)
`ifdef SEQ_HIT_COLLECTOR_TSTAMP_EN
        ,
        .HIT_TSTAMP(hit_tstamp)
`endif
    );

    always #5 SYSCLK = ~SYSCLK;

    int tests = 0;
    int fails = 0;

    // Reference model: a plain queue of entries plus counters and flag
    logic [5:0] mq[$];
    int         mcnt [3];
    logic       movf;

    typedef struct {
        logic       vld;
        logic [3:0] d;
        logic [1:0] m;
        logic       rdy;
        logic       clr;
        logic       ehv;
        logic [5:0] ehd;
        int         elvl;
        int         ec0;
        int         ec1;
        int         ec2;
        logic       eovf;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic vld, input logic [3:0] d, input logic [1:0] m,
                              input logic rdy, input logic clr, input logic rst);
        bit pop, push, room;
        if (rst) begin
            mq.delete();
            for (int k = 0; k < 3; k++) mcnt[k] = 0;
            movf = 1'b0;
            return;
        end
        pop  = (mq.size() != 0) && rdy;
        push = vld && (m != 2'd3);
        room = (mq.size() < DEPTH) || pop;
        if (pop) void'(mq.pop_front());
        if (push && room) mq.push_back({m, d});
        if (clr) begin
            for (int k = 0; k < 3; k++) mcnt[k] = 0;
            movf = 1'b0;
        end else begin
            if (push && mcnt[m] < (1 << CNT_W) - 1) mcnt[m] = mcnt[m] + 1;
            if (push && !room) movf = 1'b1;
        end
    endtask

    // Drive one cycle of inputs, advance the model, then sample 1 unit after the edge
    task automatic cyc(input logic vld, input logic [3:0] d, input logic [1:0] m,
                       input logic rdy, input logic clr, input logic rst);
        DET_VALID = vld;
        DET_DATA  = d;
        DET_MODE  = m;
        HIT_READY = rdy;
        CLR       = clr;
        RST       = rst;
        model_step(vld, d, m, rdy, clr, rst);
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_hv"},   int'(HIT_VALID), int'(mq.size() != 0));
        chk({tag, "_hd"},   int'(HIT_DATA),  (mq.size() != 0) ? int'(mq[0]) : 0);
        chk({tag, "_lvl"},  int'(LEVEL),     mq.size());
        chk({tag, "_c0"},   int'(HIT_CNT0),  mcnt[0]);
        chk({tag, "_c1"},   int'(HIT_CNT1),  mcnt[1]);
        chk({tag, "_c2"},   int'(HIT_CNT2),  mcnt[2]);
        chk({tag, "_ovf"},  int'(OVERFLOW),  int'(movf));
    endtask

    initial begin
        DET_VALID = 0; DET_DATA = 0; DET_MODE = 0; HIT_READY = 0; CLR = 0; RST = 1;

        // Reset state
        cyc(0, 4'h0, 2'd0, 0, 0, 1);
        cyc(0, 4'h0, 2'd0, 0, 0, 1);
        chk("rst_hv",  HIT_VALID, 0);
        chk("rst_hd",  HIT_DATA,  0);
        chk("rst_lvl", LEVEL,     0);
        chk("rst_c0",  HIT_CNT0,  0);
        chk("rst_c1",  HIT_CNT1,  0);
        chk("rst_c2",  HIT_CNT2,  0);
        chk("rst_ovf", OVERFLOW,  0);

        // Vector table: basic push/drain, mode-3 filter, head stability, push+pop, clear
        vt[0]  = '{1, 4'h3, 2'd0, 1, 0,  1, 6'h03, 1, 1, 0, 0, 0};
        vt[1]  = '{0, 4'h0, 2'd0, 1, 0,  0, 6'h00, 0, 1, 0, 0, 0};
        vt[2]  = '{1, 4'h5, 2'd3, 0, 0,  0, 6'h00, 0, 1, 0, 0, 0};
        vt[3]  = '{1, 4'h5, 2'd3, 0, 0,  0, 6'h00, 0, 1, 0, 0, 0};
        vt[4]  = '{1, 4'h5, 2'd3, 0, 0,  0, 6'h00, 0, 1, 0, 0, 0};
        vt[5]  = '{1, 4'h5, 2'd3, 0, 0,  0, 6'h00, 0, 1, 0, 0, 0};
        vt[6]  = '{1, 4'h5, 2'd3, 0, 0,  0, 6'h00, 0, 1, 0, 0, 0};
        vt[7]  = '{1, 4'h7, 2'd1, 0, 0,  1, 6'h17, 1, 1, 1, 0, 0};
        vt[8]  = '{1, 4'h9, 2'd2, 0, 0,  1, 6'h17, 2, 1, 1, 1, 0};
        vt[9]  = '{0, 4'h0, 2'd0, 0, 0,  1, 6'h17, 2, 1, 1, 1, 0};
        vt[10] = '{0, 4'h0, 2'd0, 1, 0,  1, 6'h29, 1, 1, 1, 1, 0};
        vt[11] = '{1, 4'hA, 2'd0, 1, 0,  1, 6'h0A, 1, 2, 1, 1, 0};
        vt[12] = '{0, 4'h0, 2'd0, 1, 1,  0, 6'h00, 0, 0, 0, 0, 0};
        for (int i = 0; i < 13; i++) begin
            cyc(vt[i].vld, vt[i].d, vt[i].m, vt[i].rdy, vt[i].clr, 0);
            chk($sformatf("vec%0d_hv", i),  HIT_VALID, vt[i].ehv);
            chk($sformatf("vec%0d_hd", i),  HIT_DATA,  vt[i].ehd);
            chk($sformatf("vec%0d_lvl", i), LEVEL,     vt[i].elvl);
            chk($sformatf("vec%0d_c0", i),  HIT_CNT0,  vt[i].ec0);
            chk($sformatf("vec%0d_c1", i),  HIT_CNT1,  vt[i].ec1);
            chk($sformatf("vec%0d_c2", i),  HIT_CNT2,  vt[i].ec2);
            chk($sformatf("vec%0d_ovf", i), OVERFLOW,  vt[i].eovf);
        end

        // Fill to DEPTH then one more: drop, sticky flag, drop still counted
        for (int i = 0; i < 9; i++) begin
            cyc(1, 4'(i), 2'd1, 0, 0, 0);
            if (i == 7) begin
                chk("fill_lvl8", LEVEL, 8);
                chk("fill_noovf", OVERFLOW, 0);
            end
        end
        chk("ovf_lvl", LEVEL, 8);
        chk("ovf_flag", OVERFLOW, 1);
        chk("ovf_cnt1", HIT_CNT1, 9);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d", i), HIT_DATA, {2'd1, 4'(i)});
            cyc(0, 4'h0, 2'd0, 1, 0, 0);
        end
        chk("drain_hv", HIT_VALID, 0);
        chk("drain_lvl", LEVEL, 0);
        chk("drain_ovf_sticky", OVERFLOW, 1);
        cyc(0, 4'h0, 2'd0, 0, 1, 0);
        chk("clr_ovf", OVERFLOW, 0);
        chk("clr_c1", HIT_CNT1, 0);

        // Push and pop together while full: accepted, no overflow
        for (int i = 0; i < 8; i++) cyc(1, 4'(i), 2'd0, 0, 0, 0);
        chk("full_lvl", LEVEL, 8);
        cyc(1, 4'hA, 2'd2, 1, 0, 0);
        chk("fullpp_lvl", LEVEL, 8);
        chk("fullpp_ovf", OVERFLOW, 0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("fullpp_out%0d", k), HIT_DATA, (k < 7) ? int'({2'd0, 4'(k + 1)}) : 'h2A);
            cyc(0, 4'h0, 2'd0, 1, 0, 0);
        end
        chk("fullpp_empty", LEVEL, 0);

        // Saturation, then clear together with a hit
        cyc(0, 4'h0, 2'd0, 0, 1, 0);
        for (int i = 0; i < 300; i++) cyc(1, 4'(i), 2'd2, 1, 0, 0);
        chk("sat_c2", HIT_CNT2, 255);
        cyc(0, 4'h0, 2'd0, 1, 0, 0);
        chk("sat_drained", LEVEL, 0);
        cyc(1, 4'h6, 2'd2, 0, 1, 0);
        chk("clrhit_c2", HIT_CNT2, 0);
        chk("clrhit_lvl", LEVEL, 1);
        chk("clrhit_hd", HIT_DATA, 'h26);

        // Clear coinciding with a drop leaves OVERFLOW low
        for (int i = 0; i < 7; i++) cyc(1, 4'(i), 2'd0, 0, 0, 0);
        chk("clrovf_full", LEVEL, 8);
        cyc(1, 4'h1, 2'd0, 0, 1, 0);
        chk("clrovf_ovf", OVERFLOW, 0);
        chk("clrovf_c0", HIT_CNT0, 0);
        cyc(1, 4'h1, 2'd0, 0, 0, 0);
        chk("drop_ovf", OVERFLOW, 1);
        chk("drop_c0", HIT_CNT0, 1);

        // Reset mid-drain discards entries
        for (int i = 0; i < 3; i++) cyc(0, 4'h0, 2'd0, 1, 0, 0);
        chk("mid_lvl5", LEVEL, 5);
        cyc(0, 4'h0, 2'd0, 0, 0, 1);
        chk("midrst_hv", HIT_VALID, 0);
        chk("midrst_lvl", LEVEL, 0);
        chk("midrst_ovf", OVERFLOW, 0);
        chk("midrst_hd", HIT_DATA, 0);
        chk("midrst_c0", HIT_CNT0, 0);

        // Random traffic against the queue model
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 60), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) == 0),
                ($urandom_range(0, 399) == 0));
            check_model("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
